// File: rtl/controle_multiciclo.sv
// Multicycle control sequencer for the nRisc core: fetch/decode/exec/mem/write-back
// sequencing on a shared memory and ALU, with memory-stall timeout and a retired-instruction counter.
module controle_multiciclo #(
   parameter int ESPERA_MAX   = 15,
   parameter int LARGURA_CONT = 16
) (
   input  logic                    Clock,
   input  logic                    Reset_n,
   input  logic [2:0]              Istrc,
   input  logic                    Zero,
   input  logic                    MemPronta,
   output logic                    EscrevePC,
   output logic                    EscreveIR,
   output logic                    LerMem,
   output logic                    EscreveMem,
   output logic                    ULASrc,
   output logic                    OpULA,
   output logic                    MemtoREG,
   output logic                    Defi,
   output logic                    EscreveReg,
   output logic                    IouD,
   output logic [1:0]              PCSrc,
   output logic                    Encerrado,
   output logic                    ErroMem,
   output logic [2:0]              Estado,
   output logic [LARGURA_CONT-1:0] NumInstr
);

   localparam int CW = (ESPERA_MAX < 2) ? 1 : $clog2(ESPERA_MAX + 1);

   localparam logic [2:0] OP_DEFI = 3'b000;
   localparam logic [2:0] OP_BEQ  = 3'b001;
   localparam logic [2:0] OP_LW   = 3'b010;
   localparam logic [2:0] OP_SW   = 3'b011;
   localparam logic [2:0] OP_MUL  = 3'b100;
   localparam logic [2:0] OP_SUBI = 3'b101;
   localparam logic [2:0] OP_J    = 3'b110;
   localparam logic [2:0] OP_ENC  = 3'b111;

   typedef enum logic [2:0] {
      BUSCA   = 3'd0,
      DECOD   = 3'd1,
      EXEC    = 3'd2,
      MEM     = 3'd3,
      ESCRITA = 3'd4,
      FIM     = 3'd5,
      ERRO    = 3'd6,
      INVAL   = 3'd7
   } estado_t;

   estado_t                 estado_r, estado_nx_s;
   logic [2:0]              op_r, op_nx_s;
   logic [CW-1:0]           espera_r, espera_nx_s;
   logic [LARGURA_CONT-1:0] num_r;
   logic                    retira_s, limite_s;
   logic                    pc_s, ir_s, lm_s, em_s, us_s, ou_s, mr_s, df_s, er_s, io_s, en_s, eo_s;
   logic [1:0]              ps_s;

   assign limite_s = (espera_r == CW'(ESPERA_MAX - 1));

   // Next-state, strobe decode and retire/wait-counter control
   always_comb begin
      estado_nx_s = estado_r;
      op_nx_s     = op_r;
      retira_s    = 1'b0;
      pc_s = 1'b0; ir_s = 1'b0; lm_s = 1'b0; em_s = 1'b0; us_s = 1'b0; ou_s = 1'b0;
      mr_s = 1'b0; df_s = 1'b0; er_s = 1'b0; io_s = 1'b0; en_s = 1'b0; eo_s = 1'b0;
      ps_s = 2'b00;
      case (estado_r)
         BUSCA: begin
            lm_s = 1'b1;
            if (MemPronta) begin
               ir_s        = 1'b1;
               pc_s        = 1'b1;
               estado_nx_s = DECOD;
            end else if (limite_s) begin
               estado_nx_s = ERRO;
            end else begin
               estado_nx_s = BUSCA;
            end
         end
         DECOD: begin
            // Istrc is only valid here; everything later decodes from op_r
            op_nx_s = Istrc;
            if (Istrc == OP_ENC) begin
               estado_nx_s = FIM;
               retira_s    = 1'b1;
            end else begin
               estado_nx_s = EXEC;
            end
         end
         EXEC: begin
            case (op_r)
               OP_DEFI: begin df_s = 1'b1; er_s = 1'b1; estado_nx_s = BUSCA; retira_s = 1'b1; end
               OP_BEQ:  begin us_s = 1'b1; ps_s = 2'b01; pc_s = Zero; estado_nx_s = BUSCA; retira_s = 1'b1; end
               OP_J:    begin ps_s = 2'b10; pc_s = 1'b1; estado_nx_s = BUSCA; retira_s = 1'b1; end
               OP_LW:   estado_nx_s = MEM;
               OP_SW:   estado_nx_s = MEM;
               OP_MUL:  begin us_s = 1'b1; ou_s = 1'b1; estado_nx_s = ESCRITA; end
               OP_SUBI: estado_nx_s = ESCRITA;
               default: estado_nx_s = BUSCA;
            endcase
         end
         MEM: begin
            io_s = 1'b1;
            lm_s = (op_r == OP_LW);
            em_s = (op_r == OP_SW);
            if (MemPronta) begin
               if (op_r == OP_LW) begin
                  estado_nx_s = ESCRITA;
               end else begin
                  estado_nx_s = BUSCA;
                  retira_s    = 1'b1;
               end
            end else if (limite_s) begin
               estado_nx_s = ERRO;
            end else begin
               estado_nx_s = MEM;
            end
         end
         ESCRITA: begin
            er_s        = 1'b1;
            mr_s        = (op_r == OP_LW);
            us_s        = (op_r == OP_MUL);
            ou_s        = (op_r == OP_MUL);
            estado_nx_s = BUSCA;
            retira_s    = 1'b1;
         end
         FIM:     en_s = 1'b1;
         ERRO:    eo_s = 1'b1;
         default: estado_nx_s = BUSCA;
      endcase

      if ((estado_nx_s != estado_r) || MemPronta) begin
         espera_nx_s = '0;
      end else if ((estado_r == BUSCA) || (estado_r == MEM)) begin
         espera_nx_s = espera_r + CW'(1);
      end else begin
         espera_nx_s = '0;
      end
   end

   // State, op, wait counter and saturating retire counter
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         estado_r <= BUSCA;
         op_r     <= 3'b000;
         espera_r <= '0;
         num_r    <= '0;
      end else begin
         estado_r <= estado_nx_s;
         op_r     <= op_nx_s;
         espera_r <= espera_nx_s;
         if (retira_s && (num_r != {LARGURA_CONT{1'b1}})) begin
            num_r <= num_r + LARGURA_CONT'(1);
         end else begin
            num_r <= num_r;
         end
      end
   end

   // Reset gates every strobe combinationally so an aborted instruction leaves nothing behind
   assign EscrevePC  = Reset_n & pc_s;
   assign EscreveIR  = Reset_n & ir_s;
   assign LerMem     = Reset_n & lm_s;
   assign EscreveMem = Reset_n & em_s;
   assign ULASrc     = Reset_n & us_s;
   assign OpULA      = Reset_n & ou_s;
   assign MemtoREG   = Reset_n & mr_s;
   assign Defi       = Reset_n & df_s;
   assign EscreveReg = Reset_n & er_s;
   assign IouD       = Reset_n & io_s;
   assign PCSrc      = {Reset_n, Reset_n} & ps_s;
   assign Encerrado  = Reset_n & en_s;
   assign ErroMem    = Reset_n & eo_s;
   assign Estado     = estado_r;
   assign NumInstr   = num_r;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench: directed scenarios plus random stimulus against an instruction-phase-table model.
module tb_controle_multiciclo;

   localparam int EMAX = 4;

   logic        Clock = 1'b0;
   logic        Reset_n;
   logic [2:0]  Istrc;
   logic        Zero, MemPronta;

   logic        EscrevePC, EscreveIR, LerMem, EscreveMem, ULASrc, OpULA, MemtoREG, Defi, EscreveReg, IouD;
   logic [1:0]  PCSrc;
   logic        Encerrado, ErroMem;
   logic [2:0]  Estado;
   logic [15:0] NumInstr;

   logic        s_pc, s_ir, s_lm, s_em, s_us, s_ou, s_mr, s_df, s_er, s_io, s_en, s_eo;
   logic [1:0]  s_ps;
   logic [2:0]  s_estado;
   logic [1:0]  s_num;

   int total = 0;
   int bad   = 0;

   int m_k, m_op, m_wait, m_cnt;
   bit m_fim, m_err;

   controle_multiciclo #(.ESPERA_MAX(EMAX), .LARGURA_CONT(16)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .Istrc(Istrc), .Zero(Zero), .MemPronta(MemPronta),
      .EscrevePC(EscrevePC), .EscreveIR(EscreveIR), .LerMem(LerMem), .EscreveMem(EscreveMem),
      .ULASrc(ULASrc), .OpULA(OpULA), .MemtoREG(MemtoREG), .Defi(Defi), .EscreveReg(EscreveReg),
      .IouD(IouD), .PCSrc(PCSrc), .Encerrado(Encerrado), .ErroMem(ErroMem),
      .Estado(Estado), .NumInstr(NumInstr)
   );

   controle_multiciclo #(.ESPERA_MAX(EMAX), .LARGURA_CONT(2)) dut_sat (
      .Clock(Clock), .Reset_n(Reset_n), .Istrc(Istrc), .Zero(Zero), .MemPronta(MemPronta),
      .EscrevePC(s_pc), .EscreveIR(s_ir), .LerMem(s_lm), .EscreveMem(s_em),
      .ULASrc(s_us), .OpULA(s_ou), .MemtoREG(s_mr), .Defi(s_df), .EscreveReg(s_er),
      .IouD(s_io), .PCSrc(s_ps), .Encerrado(s_en), .ErroMem(s_eo),
      .Estado(s_estado), .NumInstr(s_num)
   );

   always #5 Clock = ~Clock;

   wire [14:0] obs_v = {EscrevePC, EscreveIR, LerMem, EscreveMem, ULASrc, OpULA, MemtoREG,
                        Defi, EscreveReg, IouD, PCSrc, Encerrado, ErroMem};
   wire [14:0] obs_s = {s_pc, s_ir, s_lm, s_em, s_us, s_ou, s_mr, s_df, s_er, s_io, s_ps, s_en, s_eo};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Step list of each instruction, as Estado codes
   function automatic int seq_len(input int op);
      case (op)
         2:       return 5;
         3, 4, 5: return 4;
         7:       return 2;
         default: return 3;
      endcase
   endfunction

   function automatic int seq_code(input int op, input int k);
      if (k < 3)              return k;
      if (op == 2 && k == 4)  return 4;
      if (op == 2 || op == 3) return 3;
      return 4;
   endfunction

   function automatic int m_code();
      if (m_err) return 6;
      if (m_fim) return 5;
      return seq_code(m_op, m_k);
   endfunction

   function automatic logic [14:0] exp_out(input int c, input int op, input logic mp, input logic z);
      logic pc, ir, lm, em, us, ou, mr, df, er, io, en, eo;
      logic [1:0] ps;
      {pc, ir, lm, em, us, ou, mr, df, er, io, en, eo} = 12'd0;
      ps = 2'b00;
      case (c)
         0: begin lm = 1'b1; ir = mp; pc = mp; end
         2: case (op)
               0: begin df = 1'b1; er = 1'b1; end
               1: begin us = 1'b1; ps = 2'b01; pc = z; end
               4: begin us = 1'b1; ou = 1'b1; end
               6: begin ps = 2'b10; pc = 1'b1; end
               default: ;
            endcase
         3: begin io = 1'b1; lm = (op == 2); em = (op == 3); end
         4: begin er = 1'b1; mr = (op == 2); us = (op == 4); ou = (op == 4); end
         5: en = 1'b1;
         6: eo = 1'b1;
         default: ;
      endcase
      return {pc, ir, lm, em, us, ou, mr, df, er, io, ps, en, eo};
   endfunction

   task automatic model_reset();
      m_k = 0; m_op = 0; m_wait = 0; m_cnt = 0; m_fim = 0; m_err = 0;
   endtask

   task automatic model_step(input logic [2:0] ist, input logic mp);
      int c;
      if (!m_fim && !m_err) begin
         c = m_code();
         if ((c == 0 || c == 3) && !mp) begin
            m_wait++;
            if (m_wait == EMAX) begin m_err = 1; m_wait = 0; end
         end else begin
            m_wait = 0;
            if (c == 1) m_op = int'(ist);
            if (m_k == seq_len(m_op) - 1) begin
               m_cnt++;
               m_k = 0;
               if (m_op == 7) m_fim = 1;
            end else begin
               m_k++;
            end
         end
      end
   endtask

   // Starts and ends at a falling edge
   task automatic cyc(input logic [2:0] ist, input logic z, input logic mp);
      logic [14:0] e;
      Istrc = ist; Zero = z; MemPronta = mp;
      #1;
      e = exp_out(m_code(), m_op, mp, z);
      chk("strobes", 32'(obs_v), 32'(e));
      chk("strobes_sat", 32'(obs_s), 32'(e));
      chk("estado", 32'(Estado), 32'(m_code()));
      chk("estado_sat", 32'(s_estado), 32'(m_code()));
      chk("numinstr", 32'(NumInstr), 32'(m_cnt));
      chk("numinstr_sat", 32'(s_num), 32'((m_cnt > 3) ? 3 : m_cnt));
      @(posedge Clock);
      model_step(ist, mp);
      @(negedge Clock);
   endtask

   task automatic do_reset();
      #2 Reset_n = 1'b0;
      #1;
      chk("rst_strobes", 32'(obs_v), 32'd0);
      chk("rst_strobes_sat", 32'(obs_s), 32'd0);
      chk("rst_estado", 32'(Estado), 32'd0);
      chk("rst_num", 32'(NumInstr), 32'd0);
      chk("rst_num_sat", 32'(s_num), 32'd0);
      model_reset();
      @(negedge Clock);
      Reset_n = 1'b1;
   endtask

   initial begin
      int halt_cnt;
      int thr;
      logic [2:0] ist;
      Reset_n = 1'b0; Istrc = 3'd0; Zero = 1'b0; MemPronta = 1'b1;
      model_reset();
      @(negedge Clock);
      chk("init_strobes", 32'(obs_v), 32'd0);
      chk("init_estado", 32'(Estado), 32'd0);
      chk("init_num", 32'(NumInstr), 32'd0);
      @(negedge Clock);
      Reset_n = 1'b1;

      repeat (3) cyc(3'd0, 1'b0, 1'b1);
      repeat (3) cyc(3'd2, 1'b0, 1'b1);
      repeat (2) cyc(3'd2, 1'b0, 1'b0);
      repeat (2) cyc(3'd2, 1'b0, 1'b1);
      repeat (3) cyc(3'd1, 1'b1, 1'b1);
      repeat (3) cyc(3'd1, 1'b0, 1'b1);
      repeat (4) cyc(3'd4, 1'b0, 1'b1);
      repeat (4) cyc(3'd5, 1'b1, 1'b1);
      repeat (4) cyc(3'd3, 1'b0, 1'b1);

      do_reset();
      repeat (EMAX) cyc(3'd0, 1'b0, 1'b0);
      repeat (10) cyc(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
      do_reset();
      repeat (EMAX - 1) cyc(3'd0, 1'b0, 1'b0);
      repeat (3) cyc(3'd0, 1'b0, 1'b1);
      cyc(3'd3, 1'b0, 1'b1); cyc(3'd3, 1'b0, 1'b1); cyc(3'd3, 1'b0, 1'b1);
      repeat (EMAX) cyc(3'd3, 1'b0, 1'b0);

      do_reset();
      repeat (6) cyc(3'd0, 1'b0, 1'b1);
      repeat (2) cyc(3'd7, 1'b0, 1'b1);
      repeat (10) cyc(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
      do_reset();
      repeat (2) cyc(3'd0, 1'b0, 1'b1);
      do_reset();
      repeat (15) cyc(3'd6, 1'b0, 1'b1);

      halt_cnt = 0;
      thr = 2;
      for (int i = 0; i < 4000; i++) begin
         if (i % 100 == 0) thr = $urandom_range(0, 7);
         ist = 3'($urandom_range(0, 7));
         if (ist == 3'd7 && $urandom_range(0, 3) != 0) ist = 3'd0;
         cyc(ist, 1'($urandom), 1'($urandom_range(0, 9) >= thr));
         if (m_fim || m_err) halt_cnt++;
         if (halt_cnt > 6 || (i % 500 == 499)) begin
            halt_cnt = 0;
            do_reset();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
